// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and counter sizing for serial_adder
package serial_adder_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fa.sv
// rtl/fa.sv - single-bit full adder
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder driving one full adder LSB-first
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-2:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fa_sum, fa_cout;
    logic [WIDTH-1:0]   acc_next;

    fa u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // acc holds the WIDTH-1 bits already produced; with the current fa bit on top it is the full sum.
    assign acc_next = {fa_sum, acc_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                acc_d   = acc_next[WIDTH-1:1];
                carry_d = fa_cout;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = acc_next;
                    cout_d  = fa_cout;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, cin, busy, done, cout;
    logic [7:0] a, b, sum;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;

    int total = 0;
    int bad   = 0;
    logic [8:0] last_res;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                         input bit poke, input string tag);
        logic [8:0] exp;
        int busy_n, done_n, lat, hold_bad;
        exp = 9'(oa) + 9'(ob) + 9'(oc);
        busy_n = 0; done_n = 0; lat = 0; hold_bad = 0;
        @(negedge clk);
        start = 1'b1; a = oa; b = ob; cin = oc;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) @(negedge clk);
            if (poke && i == 3) begin start = 1'b1; a = 8'h01; b = 8'h01; end
            if (poke && i == 4) start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat == 0) begin
                    lat = i;
                    check({tag, ".result"}, 32'({cout, sum}), 32'(exp));
                end
            end else if (lat == 0 && {cout, sum} !== last_res) begin
                hold_bad++;
            end
        end
        check({tag, ".busy_cycles"}, 32'(busy_n), 32'd8);
        check({tag, ".done_pulses"}, 32'(done_n), 32'd1);
        check({tag, ".latency"}, 32'(lat), 32'd9);
        check({tag, ".no_partial"}, 32'(hold_bad), 32'd0);
        check({tag, ".held"}, 32'({cout, sum}), 32'(exp));
        last_res = exp;
    endtask

    initial begin
        int lat, seen;
        logic [8:0] exp;
        logic [4:0] v;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        last_res = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.result", 32'({cout, sum}), 32'd0);
        check("reset.w2", 32'({busy2, done2, cout2, sum2}), 32'd0);

        do_op(8'h00, 8'h00, 1'b0, 1'b0, "zero");
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, "wrap");
        do_op(8'hA5, 8'h5A, 1'b1, 1'b0, "a5_5a");
        do_op(8'h3C, 8'h11, 1'b0, 1'b0, "3c_11");
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0, "all_ones");
        do_op(8'h12, 8'h34, 1'b1, 1'b1, "ignore_start");

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        start = 1'b1; a = 8'h55; b = 8'h22; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort.busy_before", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.result", 32'({cout, sum}), 32'd0);
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("abort.quiet", 32'(seen), 32'd0);
        do_op(8'h10, 8'h20, 1'b0, 1'b0, "after_reset");

        // Back-to-back: start held high through DONE.
        @(negedge clk);
        start = 1'b1; a = 8'h7F; b = 8'h01; cin = 1'b0;
        lat = 0;
        for (int i = 0; i < 14 && lat == 0; i++) begin
            @(negedge clk);
            if (done) lat = 1;
        end
        check("b2b.first_done", 32'(lat), 32'd1);
        check("b2b.first_result", 32'({cout, sum}), 32'h080);
        a = 8'h80; b = 8'h80; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("b2b.no_idle_busy", 32'(busy), 32'd1);
        check("b2b.hold_prev", 32'({cout, sum}), 32'h080);
        lat = 0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            if (i > 1) @(negedge clk);
            if (done) lat = i;
        end
        check("b2b.latency", 32'(lat), 32'd9);
        check("b2b.second_result", 32'({cout, sum}), 32'h100);
        last_res = 9'h100;

        for (int r = 0; r < 20; r++)
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, $sformatf("rand%0d", r));

        // WIDTH=2: every {a,b,cin} combination.
        for (int k = 0; k < 32; k++) begin
            v = 5'(k);
            exp = 9'(v[4:3]) + 9'(v[2:1]) + 9'(v[0]);
            @(negedge clk);
            start2 = 1'b1; a2 = v[4:3]; b2 = v[2:1]; cin2 = v[0];
            @(negedge clk);
            start2 = 1'b0;
            lat = 0;
            for (int i = 1; i <= 6 && lat == 0; i++) begin
                if (i > 1) @(negedge clk);
                if (done2) lat = i;
            end
            check($sformatf("w2.lat%0d", k), 32'(lat), 32'd3);
            check($sformatf("w2.res%0d", k), 32'({cout2, sum2}), 32'(exp));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the existing single-bit full adder `fa`.
- Two operands and a carry-in are loaded in parallel. Bits are fed LSB-first through one `fa` instance, one bit per clock, with the carry held in a flip-flop between bits.
- After WIDTH bits, the block returns a parallel sum and carry-out.
- It is the sequential stage that drives `fa` and consumes its outputs: an area-minimal alternative to a ripple-carry chain.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2 to 32).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request to load a, b, cin and begin addition. Sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, sampled on the accepting edge only.
- b  input  WIDTH  operand B, sampled on the accepting edge only.
- cin  input  1  carry-in for bit 0, sampled on the accepting edge only.
- busy  output  1  high while the state is SHIFT.
- done  output  1  single-cycle pulse: sum and cout are valid.
- sum  output  WIDTH  result, registered, held until the next accepted start.
- cout  output  1  carry-out of bit WIDTH-1, registered, held like sum.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry flop and bit counter all cleared.
  - Reset mid-SHIFT aborts the operation; no done is produced.
- States: IDLE, SHIFT, DONE. Encoding is 2-bit; 2'b11 is illegal and recovers to IDLE on the next edge.
- IDLE, start=1 at edge k:
  - Latch a into shift reg A and b into shift reg B.
  - carry flop = cin, count = 0, clear the sum shift register.
  - Go to SHIFT.
  - start=0 in IDLE: stay.
- SHIFT, each edge:
  - `fa` inputs are A[0], B[0] and the carry flop.
  - `fa` sum is shifted into the sum register MSB, with the register shifting right.
  - `fa` cout is loaded into the carry flop.
  - A and B shift right, count increments.
  - When count==WIDTH-1 at the edge: transfer the final carry flop value to cout, present the full sum on the output, go to DONE.
- Latency: start accepted at edge k; done=1 in the cycle following edge k+WIDTH; busy=1 from after edge k until edge k+WIDTH.
- DONE lasts exactly one cycle (done=1, busy=0).
  - start=1 in DONE: accepted exactly as in IDLE (back-to-back operation), go to SHIFT. The sum/cout outputs keep the previous result until the new operation completes.
  - start=0 in DONE: go to IDLE.
- start in SHIFT is ignored. Operand changes while busy have no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Exact for all inputs, including the all-ones wrap.
- The sum output register updates only at the SHIFT-to-DONE transition. Intermediate partial sums are never visible on sum.
- done, busy, sum and cout are driven from flops only; there are no combinational paths from inputs to outputs.
- The bit counter is $clog2(WIDTH) bits wide and does not wrap within an operation.

Decomposition:
- Shared package/header (serial_adder_pkg): state encodings S_IDLE=2'b00, S_SHIFT=2'b01, S_DONE=2'b10; counter-width function/localparam.
- One sub-module: the existing `fa` (ports a, b, cin, sum, cout), instantiated once as u_fa.
- No other hierarchy: FSM, shift registers and carry flop live in serial_adder.

Test Plan (WIDTH=8):
- a=0x00, b=0x00, cin=0, start pulse -> done one cycle after the 8th SHIFT edge; sum=0x00, cout=0; busy high for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
- a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; then a=0x3C, b=0x11, cin=0 -> sum=0x4D, cout=0.
- Start accepted, then start re-pulsed with a=0x01, b=0x01 at SHIFT cycle 3 -> ignored; the original result is reported, and done pulses exactly once.
- rst_n driven low asynchronously (mid-cycle) at SHIFT cycle 4 -> busy/done/sum/cout read 0 immediately; after release, a fresh start 0x10+0x20 -> sum=0x30, cout=0.
- start held high across DONE with new operands 0x80+0x80 -> second operation begins without an IDLE cycle; the second done yields sum=0x00, cout=1. The exhaustive 3-bit cross-check against the `fa` truth table uses WIDTH=2 with all 32 {a,b,cin} combinations -> matches a+b+cin.
